ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port 32x32 `ram` block. It lets two independent requesters, A and B, share one `ram` instance. It serialises their read and write requests, drives the RAM control pins (`ena`, `wena`, `addr`, `data_in`), captures `data_out` for reads and returns the data to the requester that owns it. It sits directly in front of `ram` and replaces any direct requester-to-RAM wiring.

## Interface
- `ADDR_W`, 5, RAM address width (depth 2^ADDR_W = 32)
- `DATA_W`, 32, RAM data width
- `clk`  in  1  system clock, all logic on rising edge; same clock as `ram`
- `rst_n`  in  1  reset, synchronous, active-low
- `req_a` / `req_b`  in  1  access request, held until granted
- `we_a` / `we_b`  in  1  1 = write, 0 = read; stable while req high
- `addr_a` / `addr_b`  in  ADDR_W  word address; stable while req high
- `wdata_a` / `wdata_b`  in  DATA_W  write data; stable while req high
- `gnt_a` / `gnt_b`  out  1  one-cycle pulse: request accepted and executing this cycle
- `rvalid_a` / `rvalid_b`  out  1  one-cycle pulse: `rdata_x` valid (reads only)
- `rdata_a` / `rdata_b`  out  DATA_W  read data, held until next read for that port
- `busy`  out  1  high while an access is in flight (state ACCESS)
- `ram_ena`, `ram_wena`  out  1  to `ram` `ena` / `wena`
- `ram_addr`  out  ADDR_W  to `ram` `addr`
- `ram_data_in`  out  DATA_W  to `ram` `data_in`
- `ram_data_out`  in  DATA_W  from `ram` `data_out`; valid while `ram_ena`=1 and `ram_wena`=0; Z otherwise, never sampled then

## Operation
- States: IDLE, ACCESS.
- IDLE:
  - No request: stay in IDLE, `ram_ena`=0.
  - Any request: pick a winner, register its `we`/`addr`/`wdata` into `ram_wena`/`ram_addr`/`ram_data_in`, set `ram_ena`=1 and the winner's `gnt`, then go to ACCESS.
- ACCESS (always exactly one cycle):
  - `ram_ena`=1 and the winner's `gnt`=1.
  - Write: the RAM stores the data at the closing edge.
  - Read: `ram_data_out` is captured into the winner's `rdata` at the closing edge, and the winner's `rvalid` is set.
  - Next state is always IDLE. Controls return to `ram_ena`=0 and `ram_wena`=0; `ram_addr` and `ram_data_in` hold their values.
- Arbitration is round-robin through a 1-bit priority pointer `pri` (0 = A favoured):
  - Only one port requesting: that port wins.
  - Both requesting: the port selected by `pri` wins.
  - After each grant, `pri` points at the loser.
- Requester rule: after seeing `gnt`=1 at a rising edge, a requester drops `req`, or presents a new request, in the following cycle. The arbiter never samples `req` during ACCESS.
- Reset (`rst_n`=0 at an edge) clears every output to 0, sets state to IDLE and sets `pri`=0.
- Reset asserted during ACCESS: the RAM still sees `ena`=1 for that cycle, so a pending write completes. A pending read is discarded (no `rvalid`).
- Read and write to the same address back-to-back from different ports: the read returns the newly written value, because the accesses are strictly serialised.

## Timing
- Request sampled in IDLE cycle N:
  - `gnt` high in N+1.
  - Write committed at the edge ending N+1.
  - `rvalid` and `rdata` presented in N+2.
- Throughput: one access per 2 cycles.
- Worst-case wait for a continuously requesting port: 4 cycles from `req` to `gnt`, since at most one access by the other port comes first.
- `gnt_a` and `gnt_b` are never high together. `rvalid_a` and `rvalid_b` are never high together.
- `rvalid` may coincide with the next request's IDLE cycle.

## Structure
- Shared package `ram_arb_pkg`: `ADDR_W` and `DATA_W` defaults, and the state encoding (IDLE=1'b0, ACCESS=1'b1).
- One sub-module, `rr_pick2`: combinational winner select from `req_a`, `req_b` and `pri`. Outputs `win_valid` and `win_sel`.
- FSM, the capture registers and RAM-pin drive stay in `ram_arbiter`. The bench instantiates the real `ram`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both requests high. Required: all outputs 0, no `gnt`. On release, the first grant goes to A.
- Single write then read on A:
  - Write addr 5'h03, wdata 32'h0000_0010.
  - Then read addr 5'h03.
  - Required: `rvalid_a` in N+2 and `rdata_a`=32'h0000_0010.
- Contention: `req_a` and `req_b` held high continuously for 8 grants. Required grant order is A,B,A,B,A,B,A,B and each `gnt` is 2 cycles apart.
- Cross-port coherency:
  - B writes 32'hDEAD_BEEF to addr 5'h1F.
  - A reads addr 5'h1F on the next grant.
  - Required: `rdata_a`=32'hDEAD_BEEF, and `rvalid_b` never pulses.
- Reset mid-op:
  - Assert `rst_n`=0 during the ACCESS cycle of A's write of 32'h1234_5678 to addr 5'h07. Required: the write lands and reads back as 32'h1234_5678 after reset.
  - Assert reset during a read's ACCESS cycle. Required: no `rvalid`.
- Wrap-around:
  - Write addr = data for every address 0..31, incrementing `addr` from 31 to 0.
  - Read back all 32 addresses.
  - Required: every word matches, and address 0 has not been overwritten by the wrap.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared widths and encodings for the two-port RAM arbiter.
// Imported by the interface, the picker and the arbiter top.
package ram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the arbiter: both request ports plus busy.
// master = requesters, slave = arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              busy;

    modport master (
        output req_a, req_b, we_a, we_b,
        output addr_a, addr_b, wdata_a, wdata_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  req_a, req_b, we_a, we_b,
        input  addr_a, addr_b, wdata_a, wdata_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b,
        output rdata_a, rdata_b, busy
    );

endinterface

// File: rtl/ram.sv
// Single-port 32x32 RAM: synchronous write, combinational read.
// data_out is only driven while a read is enabled.
module ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              ena,
    input  logic              wena,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (ena && wena) begin
            mem[addr] <= data_in;
        end
    end

    assign data_out = (ena && !wena) ? mem[addr] : 'z;

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select.
// pri breaks the tie only when both ports request.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_e pri,
    output logic  win_valid,
    output port_e win_sel
);

    always_comb begin
        win_valid = req_a | req_b;
        win_sel   = PORT_A;
        if (req_a && req_b) begin
            win_sel = pri;
        end else if (req_b) begin
            win_sel = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between
// two requesters; one registered access per two cycles.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_e            state_q;
    port_e             pri_q;
    port_e             sel_q;
    logic              gnt_a_q;
    logic              gnt_b_q;
    logic              rvalid_a_q;
    logic              rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;
    logic              busy_q;
    logic              ram_ena_q;
    logic              ram_wena_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_in_q;

    logic              win_valid;
    port_e             win_sel;

    rr_pick2 u_pick (
        .req_a     (bus.req_a),
        .req_b     (bus.req_b),
        .pri       (pri_q),
        .win_valid (win_valid),
        .win_sel   (win_sel)
    );

    // ram_ena is already high in ACCESS, so a reset landing on that
    // edge still lets the RAM finish a pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pri_q         <= PORT_A;
            sel_q         <= PORT_A;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            rvalid_a_q    <= 1'b0;
            rvalid_b_q    <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
            busy_q        <= 1'b0;
            ram_ena_q     <= 1'b0;
            ram_wena_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rvalid_a_q <= 1'b0;
                    rvalid_b_q <= 1'b0;
                    if (win_valid) begin
                        state_q   <= ACCESS;
                        sel_q     <= win_sel;
                        pri_q     <= (win_sel == PORT_A) ? PORT_B : PORT_A;
                        busy_q    <= 1'b1;
                        ram_ena_q <= 1'b1;
                        gnt_a_q   <= (win_sel == PORT_A);
                        gnt_b_q   <= (win_sel == PORT_B);
                        if (win_sel == PORT_B) begin
                            ram_wena_q    <= bus.we_b;
                            ram_addr_q    <= bus.addr_b;
                            ram_data_in_q <= bus.wdata_b;
                        end else begin
                            ram_wena_q    <= bus.we_a;
                            ram_addr_q    <= bus.addr_a;
                            ram_data_in_q <= bus.wdata_a;
                        end
                    end
                end
                ACCESS: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    gnt_a_q    <= 1'b0;
                    gnt_b_q    <= 1'b0;
                    ram_ena_q  <= 1'b0;
                    ram_wena_q <= 1'b0;
                    if (!ram_wena_q) begin
                        if (sel_q == PORT_B) begin
                            rdata_b_q  <= ram_data_out;
                            rvalid_b_q <= 1'b1;
                        end else begin
                            rdata_a_q  <= ram_data_out;
                            rvalid_a_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.busy     = busy_q;
    assign ram_ena      = ram_ena_q;
    assign ram_wena     = ram_wena_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_in  = ram_data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with the real ram behind it: directed table,
// corner sequences and random traffic against a transaction-level model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    wire  [DATA_W-1:0] ram_data_out;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ram_ena      (ram_ena),
        .ram_wena     (ram_wena),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk      (clk),
        .ena      (ram_ena),
        .wena     (ram_wena),
        .addr     (ram_addr),
        .data_in  (ram_data_in),
        .data_out (ram_data_out)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: memory array, last winner, and
    // whether an access is in flight this cycle.
    bit          chk_en = 0;
    bit          inflight = 0;
    bit          last_b = 1;
    logic [31:0] mem_m [32];
    bit          acc_b;
    bit          acc_we;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wd;
    bit          e_gnt_a = 0, e_gnt_b = 0, e_rv_a = 0, e_rv_b = 0;
    bit          e_busy = 0, e_ena = 0, e_wena = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_din = '0, e_rd_a = '0, e_rd_b = '0;
    int          gl_port[$];
    int          gl_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("gnt_a", bus.gnt_a, e_gnt_a);
            check("gnt_b", bus.gnt_b, e_gnt_b);
            check("rvalid_a", bus.rvalid_a, e_rv_a);
            check("rvalid_b", bus.rvalid_b, e_rv_b);
            check("rdata_a", bus.rdata_a, e_rd_a);
            check("rdata_b", bus.rdata_b, e_rd_b);
            check("busy", bus.busy, e_busy);
            check("ram_ena", ram_ena, e_ena);
            check("ram_wena", ram_wena, e_wena);
            check("ram_addr", ram_addr, e_addr);
            check("ram_data_in", ram_data_in, e_din);
            if (bus.gnt_a) begin gl_port.push_back(0); gl_cyc.push_back(cyc); end
            if (bus.gnt_b) begin gl_port.push_back(1); gl_cyc.push_back(cyc); end
            e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
            e_busy = 0; e_ena = 0; e_wena = 0;
            if (inflight) begin
                if (acc_we) mem_m[acc_addr] = acc_wd;
                else if (rst_n) begin
                    if (acc_b) begin e_rv_b = 1; e_rd_b = mem_m[acc_addr]; end
                    else begin e_rv_a = 1; e_rd_a = mem_m[acc_addr]; end
                end
                inflight = 0;
            end else if (rst_n && (bus.req_a || bus.req_b)) begin
                acc_b    = (bus.req_a && bus.req_b) ? !last_b : bus.req_b;
                last_b   = acc_b;
                acc_we   = acc_b ? bus.we_b : bus.we_a;
                acc_addr = acc_b ? bus.addr_b : bus.addr_a;
                acc_wd   = acc_b ? bus.wdata_b : bus.wdata_a;
                e_gnt_a = !acc_b; e_gnt_b = acc_b;
                e_busy = 1; e_ena = 1; e_wena = acc_we;
                e_addr = acc_addr; e_din = acc_wd;
                inflight = 1;
            end
            if (!rst_n) begin
                e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
                e_busy = 0; e_ena = 0; e_wena = 0;
                e_addr = '0; e_din = '0; e_rd_a = '0; e_rd_b = '0;
                inflight = 0; last_b = 1;
            end
        end
    end

    typedef struct {
        bit          pb;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic do_req(input bit pb, input bit we, input logic [4:0] a,
                          input logic [31:0] d, output int waitc);
        @(posedge clk); #2;
        if (pb) begin
            bus.req_b = 1; bus.we_b = we; bus.addr_b = a; bus.wdata_b = d;
        end else begin
            bus.req_a = 1; bus.we_a = we; bus.addr_a = a; bus.wdata_a = d;
        end
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!(pb ? bus.gnt_b : bus.gnt_a) && waitc < 12);
        check(pb ? "gnt_arrival_b" : "gnt_arrival_a",
              pb ? bus.gnt_b : bus.gnt_a, 1);
        check("gnt_wait_bound", 32'(waitc <= 4), 1);
    endtask

    task automatic rel(input bit pb);
        @(posedge clk); #2;
        if (pb) bus.req_b = 0;
        else bus.req_a = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        int w;
        do_req(v.pb, v.we, v.addr, v.wd, w);
        check("gnt_latency", w, 2);
        rel(v.pb);
        @(negedge clk);
        if (!v.we) begin
            check("vec_rvalid", v.pb ? bus.rvalid_b : bus.rvalid_a, 1);
            check("vec_rdata", v.pb ? bus.rdata_b : bus.rdata_a, v.exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        int   base;
        vec_t v;

        tbl[0] = '{0, 1, 5'h03, 32'h0000_0010, 32'h0};
        tbl[1] = '{0, 0, 5'h03, 32'h0,         32'h0000_0010};
        tbl[2] = '{1, 1, 5'h1F, 32'hDEAD_BEEF, 32'h0};
        tbl[3] = '{0, 0, 5'h1F, 32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{0, 1, 5'h0A, 32'hCAFE_F00D, 32'h0};
        tbl[5] = '{1, 0, 5'h0A, 32'h0,         32'hCAFE_F00D};
        tbl[6] = '{1, 1, 5'h03, 32'h55AA_55AA, 32'h0};
        tbl[7] = '{0, 0, 5'h03, 32'h0,         32'h55AA_55AA};
        tbl[8] = '{1, 0, 5'h1F, 32'h0,         32'hDEAD_BEEF};

        // Reset held three edges with both ports requesting.
        rst_n = 0;
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5'h10; bus.wdata_a = 32'h1;
        bus.req_b = 1; bus.we_b = 1; bus.addr_b = 5'h11; bus.wdata_b = 32'h2;
        @(posedge clk); #1 chk_en = 1;
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
            check("rst_ram_ena", ram_ena, 0);
        end
        @(posedge clk); #2 rst_n = 1;
        k = 0;
        while (!(bus.gnt_a || bus.gnt_b) && k < 6) begin @(negedge clk); k++; end
        check("first_gnt_a", bus.gnt_a, 1);
        rel(0);
        k = 0;
        while (!bus.gnt_b && k < 6) begin @(negedge clk); k++; end
        check("second_gnt_b", bus.gnt_b, 1);
        rel(1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

        // Contention: both held high for eight grants.
        base = gl_port.size();
        fork
            begin
                int wa;
                for (int i = 0; i < 4; i++) do_req(0, 0, 5'h03, 0, wa);
                rel(0);
            end
            begin
                int wb;
                for (int i = 0; i < 4; i++) do_req(1, 0, 5'h1F, 0, wb);
                rel(1);
            end
        join
        repeat (2) @(negedge clk);
        check("cont_count", gl_port.size() - base, 8);
        for (int i = 0; i < 8 && base + i < gl_port.size(); i++) begin
            check("cont_order", gl_port[base+i], i % 2);
            if (i > 0)
                check("cont_spacing", gl_cyc[base+i] - gl_cyc[base+i-1], 2);
        end

        // Reset during a write's ACCESS cycle: write must land.
        @(posedge clk); #2;
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5'h07; bus.wdata_a = 32'h1234_5678;
        @(posedge clk); #2 rst_n = 0;
        @(negedge clk);
        check("wr_rst_gnt", bus.gnt_a, 1);
        @(posedge clk); #2 bus.req_a = 0;
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        v = '{0, 0, 5'h07, 32'h0, 32'h1234_5678};
        apply_vec(v);

        // Reset during a read's ACCESS cycle: no rvalid.
        @(posedge clk); #2;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5'h07;
        @(posedge clk); #2 rst_n = 0;
        @(negedge clk);
        check("rd_rst_gnt", bus.gnt_a, 1);
        @(posedge clk); #2 bus.req_a = 0;
        @(negedge clk);
        check("rd_rst_no_rvalid", bus.rvalid_a, 0);
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);

        // Wrap-around: addresses 31,0,1..30 written with their index.
        for (int i = 0; i < 32; i++) begin
            v.pb = i[0]; v.we = 1; v.addr = 5'((31 + i) % 32);
            v.wd = 32'(v.addr); v.exp = 0;
            apply_vec(v);
        end
        for (int i = 0; i < 32; i++) begin
            v.pb = !i[0]; v.we = 0; v.addr = 5'(i); v.wd = 0; v.exp = 32'(i);
            apply_vec(v);
        end

        // Random traffic from both ports.
        fork
            begin
                int wa, gap;
                for (int i = 0; i < 40; i++) begin
                    do_req(0, 1'($urandom_range(1)), 5'($urandom_range(31)),
                           $urandom, wa);
                    gap = $urandom_range(2);
                    if (gap > 0) begin rel(0); repeat (gap - 1) @(posedge clk); end
                end
                rel(0);
            end
            begin
                int wb, gap;
                for (int i = 0; i < 40; i++) begin
                    do_req(1, 1'($urandom_range(1)), 5'($urandom_range(31)),
                           $urandom, wb);
                    gap = $urandom_range(2);
                    if (gap > 0) begin rel(1); repeat (gap - 1) @(posedge clk); end
                end
                rel(1);
            end
        join
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
